// File: rtl/reg_file_mp_pkg.sv
// Shared constants and clear-engine state encoding for the multi-port register file.
package reg_file_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read path: zero-register override, then write bypass, then array data.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              byp_en_i,
  input  logic [1:0]        wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr0_i,
  input  logic [ADDR_W-1:0] wr_addr1_i,
  input  logic [DATA_W-1:0] wr_data0_i,
  input  logic [DATA_W-1:0] wr_data1_i,
  output logic [DATA_W-1:0] rd_data_o
);

  always_comb begin
    rd_data_o = arr_data_i;
    if (ZERO_REG && (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end else if (BYPASS && byp_en_i) begin
      // Port 1 is checked first so it wins, matching the array write priority.
      if (wr_en_i[1] && (wr_addr1_i == rd_addr_i)) begin
        rd_data_o = wr_data1_i;
      end else if (wr_en_i[0] && (wr_addr0_i == rd_addr_i)) begin
        rd_data_o = wr_data0_i;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: two write ports, NUM_RD combinational read ports,
// optional write bypass and a one-register-per-cycle bulk-clear sweep.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_conflict,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_conflict_q, wr_conflict_d;
  logic              wr_drop_q, wr_drop_d;
  logic              idle;
  logic              we0, we1;

  assign idle = (state_q == IDLE);
  assign we0  = idle && wr_en[0] && !(ZERO_REG && (wr_addr0 == '0));
  assign we1  = idle && wr_en[1] && !(ZERO_REG && (wr_addr1 == '0));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_conflict_d = idle && (&wr_en) && (wr_addr0 == wr_addr1);
    wr_drop_d     = !idle && (|wr_en);
    if (state_q == IDLE) begin
      if (clr_req) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == '1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_conflict_q <= 1'b0;
      wr_drop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_conflict_q <= wr_conflict_d;
      wr_drop_q     <= wr_drop_d;
    end
  end

  // Port 1 is assigned last so it overrides port 0 on a shared address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else if (!idle) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  assign clr_busy    = (state_q == SWEEP);
  assign wr_conflict = wr_conflict_q;
  assign wr_drop     = wr_drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rd_addr_i (addr),
      .arr_data_i(mem_q[addr]),
      .byp_en_i  (idle),
      .wr_en_i   (wr_en),
      .wr_addr0_i(wr_addr0),
      .wr_addr1_i(wr_addr1),
      .wr_data0_i(wr_data0),
      .wr_data1_i(wr_data1),
      .rd_data_o (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default, no-bypass and small-parameter instances.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  wr_en;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        clr_req;
  logic        busy_a, conf_a, drop_a, busy_b, conf_b, drop_b;

  logic [11:0] c_rd_addr;
  logic [63:0] c_rd_data;
  logic [1:0]  c_wr_en;
  logic [2:0]  c_wa0, c_wa1;
  logic [15:0] c_wd0, c_wd1;
  logic        c_clr, c_busy, c_conf, c_drop;

  reg_file_mp u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .clr_req(clr_req),
    .clr_busy(busy_a), .wr_conflict(conf_a), .wr_drop(drop_a)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .clr_req(clr_req),
    .clr_busy(busy_b), .wr_conflict(conf_b), .wr_drop(drop_b)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_small (
    .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .wr_en(c_wr_en), .wr_addr0(c_wa0), .wr_addr1(c_wa1),
    .wr_data0(c_wd0), .wr_data1(c_wd1), .clr_req(c_clr),
    .clr_busy(c_busy), .wr_conflict(c_conf), .wr_drop(c_drop)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain register array plus "registers left to sweep".
  logic [31:0] m [32];
  int          sweep_left;
  int          sweep_idx;
  logic        exp_conf, exp_drop;
  logic [15:0] c_m [8];

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && sweep_left == 0) begin
      if (wr_en[1] && wr_addr1 == a) return wr_data1;
      if (wr_en[0] && wr_addr0 == a) return wr_data0;
    end
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    for (int i = 0; i < 8; i++) c_m[i] = 16'd0;
    sweep_left = 0;
    sweep_idx  = 0;
    exp_conf   = 1'b0;
    exp_drop   = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUTs.
  task automatic tick();
    if (sweep_left == 0) begin
      exp_drop = 1'b0;
      exp_conf = (wr_en == 2'b11) && (wr_addr0 == wr_addr1);
      if (wr_en[0] && wr_addr0 != 5'd0) m[wr_addr0] = wr_data0;
      if (wr_en[1] && wr_addr1 != 5'd0) m[wr_addr1] = wr_data1;
      if (clr_req) begin
        sweep_left = 32;
        sweep_idx  = 0;
      end
    end else begin
      exp_conf = 1'b0;
      exp_drop = (wr_en != 2'b00);
      m[sweep_idx] = 32'd0;
      sweep_idx++;
      sweep_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = 2'b00;
    clr_req  = 1'b0;
    c_wr_en  = 2'b00;
    c_clr    = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy_a, conf_a, drop_a, busy_b, conf_b, drop_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {busy_a, conf_a, drop_a, busy_b, conf_b, drop_b});
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(31 - i)};
      #1;
      checks++;
      if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
        failures++;
        $display("FAIL reset_read r%0d got=%h/%h exp=0", i, rd_data_a, rd_data_b);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_defaults();
    wr_en = 2'b01; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF; rd_addr = '0;
    tick();
    wr_en = 2'b00;
    rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_data_b[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL defaults_r5 got=%h/%h exp=deadbeef", rd_data_a[31:0], rd_data_b[31:0]);
    end
    checks++;
    if (rd_data_a[63:32] !== 32'd0 || rd_data_b[63:32] !== 32'd0) begin
      failures++;
      $display("FAIL defaults_r0 got=%h/%h exp=0", rd_data_a[63:32], rd_data_b[63:32]);
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b11; wr_addr0 = 5'd7; wr_addr1 = 5'd7;
    wr_data0 = 32'h11; wr_data1 = 32'h22;
    rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd_data_a !== {32'h22, 32'h22}) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data_a, {32'h22, 32'h22});
    end
    checks++;
    if (rd_data_b !== 64'd0) begin
      failures++;
      $display("FAIL nobypass_old_value got=%h exp=0", rd_data_b);
    end
    tick();
    checks++;
    if (conf_a !== 1'b1 || conf_b !== 1'b1) begin
      failures++;
      $display("FAIL bypass_conflict got=%b/%b exp=1", conf_a, conf_b);
    end
    wr_en = 2'b00;
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'h22 || rd_data_b[31:0] !== 32'h22) begin
      failures++;
      $display("FAIL bypass_stored got=%h/%h exp=22", rd_data_a[31:0], rd_data_b[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 2'b11; wr_addr0 = 5'd0; wr_addr1 = 5'd0;
    wr_data0 = 32'hFFFFFFFF; wr_data1 = 32'hFFFFFFFF;
    rd_addr = '0;
    #1;
    checks++;
    if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
      failures++;
      $display("FAIL zero_bypass got=%h/%h exp=0", rd_data_a, rd_data_b);
    end
    tick();
    checks++;
    if (conf_a !== 1'b1 || conf_b !== 1'b1) begin
      failures++;
      $display("FAIL zero_conflict got=%b/%b exp=1", conf_a, conf_b);
    end
    wr_en = 2'b00;
    tick();
    checks++;
    if (rd_data_a !== 64'd0 || conf_a !== 1'b0) begin
      failures++;
      $display("FAIL zero_after got=%h conf=%b exp=0/0", rd_data_a, conf_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en    = 2'($urandom);
      wr_addr0 = 5'($urandom);
      wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom);
      wr_data0 = $urandom;
      wr_data1 = $urandom;
      rd_addr[4:0] = ($urandom_range(0, 1) == 0) ? wr_addr0 : 5'($urandom);
      rd_addr[9:5] = ($urandom_range(0, 1) == 0) ? wr_addr1 : 5'($urandom);
      #1;
      checks++;
      if (rd_data_a[31:0] !== exp_rd(rd_addr[4:0], 1'b1) ||
          rd_data_a[63:32] !== exp_rd(rd_addr[9:5], 1'b1)) begin
        failures++;
        $display("FAIL random_read_byp n=%0d got=%h exp=%h%h", n, rd_data_a,
                 exp_rd(rd_addr[9:5], 1'b1), exp_rd(rd_addr[4:0], 1'b1));
      end
      checks++;
      if (rd_data_b[31:0] !== exp_rd(rd_addr[4:0], 1'b0) ||
          rd_data_b[63:32] !== exp_rd(rd_addr[9:5], 1'b0)) begin
        failures++;
        $display("FAIL random_read_nobyp n=%0d got=%h exp=%h%h", n, rd_data_b,
                 exp_rd(rd_addr[9:5], 1'b0), exp_rd(rd_addr[4:0], 1'b0));
      end
      tick();
      checks++;
      if (conf_a !== exp_conf || conf_b !== exp_conf || drop_a !== exp_drop) begin
        failures++;
        $display("FAIL random_flags n=%0d got=%b%b%b exp=%b%b%b", n, conf_a, conf_b, drop_a,
                 exp_conf, exp_conf, exp_drop);
      end
    end
    wr_en = 2'b00;
  endtask

  task automatic test_bulk_clear();
    int busy_cnt_a = 0;
    int busy_cnt_b = 0;
    for (int i = 1; i < 32; i += 2) begin
      wr_en    = (i == 31) ? 2'b01 : 2'b11;
      wr_addr0 = 5'(i);
      wr_addr1 = 5'(i + 1);
      wr_data0 = 32'(i);
      wr_data1 = 32'(i + 1);
      tick();
    end
    wr_en = 2'b00;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rd_addr  = {5'd3, 5'd31};
      wr_en    = (c == 10) ? 2'b01 : 2'b00;
      wr_addr0 = 5'd3;
      wr_data0 = 32'h33;
      #1;
      checks++;
      if (rd_data_a[31:0] !== exp_rd(5'd31, 1'b1) || rd_data_a[63:32] !== exp_rd(5'd3, 1'b1)) begin
        failures++;
        $display("FAIL sweep_read c=%0d got=%h exp=%h%h", c, rd_data_a,
                 exp_rd(5'd3, 1'b1), exp_rd(5'd31, 1'b1));
      end
      checks++;
      if (busy_a !== (sweep_left != 0)) begin
        failures++;
        $display("FAIL sweep_busy c=%0d got=%b exp=%b", c, busy_a, sweep_left != 0);
      end
      if (busy_a === 1'b1) busy_cnt_a++;
      if (busy_b === 1'b1) busy_cnt_b++;
      tick();
      checks++;
      if (drop_a !== exp_drop || drop_b !== exp_drop) begin
        failures++;
        $display("FAIL sweep_drop c=%0d got=%b/%b exp=%b", c, drop_a, drop_b, exp_drop);
      end
    end
    wr_en = 2'b00;
    checks++;
    if (busy_cnt_a != 32 || busy_cnt_b != 32) begin
      failures++;
      $display("FAIL sweep_length got=%0d/%0d exp=32", busy_cnt_a, busy_cnt_b);
    end
    rd_addr = {5'd3, 5'd31};
    #1;
    checks++;
    if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
      failures++;
      $display("FAIL sweep_result got=%h/%h exp=0", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_reset_mid();
    int busy_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      wr_en = 2'b11; wr_addr0 = 5'($urandom); wr_addr1 = 5'($urandom);
      wr_data0 = $urandom; wr_data1 = $urandom;
      tick();
    end
    wr_en = 2'b00;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || conf_a !== 1'b0 || drop_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_flags got=%b%b%b%b exp=0000", busy_a, busy_b, conf_a, drop_a);
    end
    model_reset();
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      checks++;
      if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
        failures++;
        $display("FAIL reset_mid_read r%0d got=%h/%h exp=0", i, rd_data_a, rd_data_b);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy_a === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != 32) begin
      failures++;
      $display("FAIL reset_mid_resweep got=%0d exp=32", busy_cnt);
    end
  endtask

  task automatic test_param_corner();
    int       busy_cnt = 0;
    logic [2:0] a [4];
    for (int i = 1; i < 8; i++) begin
      c_wr_en = 2'b01;
      c_wa0   = 3'(i);
      c_wd0   = 16'($urandom);
      c_m[i]  = c_wd0;
      tick();
    end
    c_wr_en = 2'b00;
    for (int r = 0; r < 4; r++) begin
      a[0] = 3'($urandom);
      for (int k = 1; k < 4; k++) a[k] = a[0] + 3'(k);
      c_rd_addr = {a[3], a[2], a[1], a[0]};
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (c_rd_data[k*16 +: 16] !== ((a[k] == 3'd0) ? 16'd0 : c_m[a[k]])) begin
          failures++;
          $display("FAIL small_read port%0d addr=%0d got=%h exp=%h", k, a[k], c_rd_data[k*16 +: 16],
                   (a[k] == 3'd0) ? 16'd0 : c_m[a[k]]);
        end
      end
    end
    c_clr = 1'b1;
    tick();
    for (int c = 0; c < 16; c++) begin
      c_clr = (c == 3 || c == 7);
      if (c_busy === 1'b1) busy_cnt++;
      tick();
    end
    c_clr = 1'b0;
    checks++;
    if (busy_cnt != 8) begin
      failures++;
      $display("FAIL small_sweep_length got=%0d exp=8", busy_cnt);
    end
    for (int g = 0; g < 2; g++) begin
      c_rd_addr = {3'(g * 4 + 3), 3'(g * 4 + 2), 3'(g * 4 + 1), 3'(g * 4)};
      #1;
      checks++;
      if (c_rd_data !== 64'd0) begin
        failures++;
        $display("FAIL small_sweep_result group=%0d got=%h exp=0", g, c_rd_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1;
    rd_addr = '0; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    c_rd_addr = '0; c_wa0 = '0; c_wa1 = '0; c_wd0 = '0; c_wd1 = '0;
    idle_inputs();
    model_reset();
    test_reset();
    test_defaults();
    test_bypass();
    test_zero_reg();
    test_random();
    test_bulk_clear();
    test_reset_mid();
    test_param_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
